// File: rtl/apb_vgachargen_if_if.sv
// rtl/apb_vgachargen_if_if.sv - APB3 bus bundle between an APB master and apb_vgachargen_if
// Signals keep the slave-side names: *_i driven by the master, *_o driven by the slave.
//   psel_i, penable_i, pwrite_i, paddr_i[APB_ADDR_WIDTH], pwdata_i[32]  master -> slave
//   prdata_o[32], pready_o, pslverr_o                                   slave -> master
interface apb_vgachargen_if_if #(
  parameter int APB_ADDR_WIDTH = 16
);
  logic                      psel_i;
  logic                      penable_i;
  logic                      pwrite_i;
  logic [APB_ADDR_WIDTH-1:0] paddr_i;
  logic [31:0]               pwdata_i;
  logic [31:0]               prdata_o;
  logic                      pready_o;
  logic                      pslverr_o;

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    input  prdata_o, pready_o, pslverr_o
  );

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    output prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/apb_vgachargen_if.sv
// rtl/apb_vgachargen_if.sv - APB3 slave decoding transfers onto the vgachargen col_map, ch_map and glyph memory ports
// Ports:
//   sys_clk_i, sys_arstn_i           clock, asynchronous active-low reset
//   bus                              APB3 slave (apb_vgachargen_if_if.slave)
//   col_map_addr_o/data_o/wen_o/data_i  col_map port, 8-bit data, 1-cycle read latency
//   ch_map_addr_o/data_o/wen_o/data_i   ch_map port, CH_MAP_DATA_WIDTH data, 1-cycle read latency
//   ch_t_rw_addr_o/data_o/wen_o/data_i  glyph table port, CH_T_DATA_WIDTH data, 1-cycle read latency
// Address map (byte address, idx = paddr[13:2]):
//   0x0000 col_map[idx], 0x4000 ch_map[idx], 0x8000 glyph idx[8:2] word idx[1:0], 0xC000 error
module apb_vgachargen_if #(
  parameter int APB_ADDR_WIDTH     = 16,
  parameter int COL_MAP_ADDR_WIDTH = 12,
  parameter int CH_MAP_ADDR_WIDTH  = 12,
  parameter int CH_MAP_DATA_WIDTH  = 8,
  parameter int CH_T_ADDR_WIDTH    = 7,
  parameter int CH_T_DATA_WIDTH    = 128,
  parameter int MAP_DEPTH          = 2400
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_arstn_i,
  apb_vgachargen_if_if.slave            bus,
  output logic [COL_MAP_ADDR_WIDTH-1:0] col_map_addr_o,
  output logic [7:0]                    col_map_data_o,
  output logic                          col_map_wen_o,
  input  logic [7:0]                    col_map_data_i,
  output logic [CH_MAP_ADDR_WIDTH-1:0]  ch_map_addr_o,
  output logic [CH_MAP_DATA_WIDTH-1:0]  ch_map_data_o,
  output logic                          ch_map_wen_o,
  input  logic [CH_MAP_DATA_WIDTH-1:0]  ch_map_data_i,
  output logic [CH_T_ADDR_WIDTH-1:0]    ch_t_rw_addr_o,
  output logic [CH_T_DATA_WIDTH-1:0]    ch_t_rw_data_o,
  output logic                          ch_t_rw_wen_o,
  input  logic [CH_T_DATA_WIDTH-1:0]    ch_t_rw_data_i
);
  localparam int NW = CH_T_DATA_WIDTH / 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    ERR  = 3'd4
  } state_e;

  state_e                        state_q, state_d;
  logic [1:0]                    region_q, region_d;
  logic [1:0]                    word_q, word_d;
  logic                          pready_q, pready_d;
  logic                          pslverr_q, pslverr_d;
  logic [COL_MAP_ADDR_WIDTH-1:0] col_addr_q, col_addr_d;
  logic [7:0]                    col_data_q, col_data_d;
  logic                          col_wen_q, col_wen_d;
  logic [CH_MAP_ADDR_WIDTH-1:0]  ch_addr_q, ch_addr_d;
  logic [CH_MAP_DATA_WIDTH-1:0]  ch_data_q, ch_data_d;
  logic                          ch_wen_q, ch_wen_d;
  logic [CH_T_ADDR_WIDTH-1:0]    cht_addr_q, cht_addr_d;
  logic [CH_T_DATA_WIDTH-1:0]    cht_data_q, cht_data_d;
  logic                          cht_wen_q, cht_wen_d;
  logic [CH_T_DATA_WIDTH-1:0]    shadow_q, shadow_d;

  logic [APB_ADDR_WIDTH-1:0]     paddr;
  logic [11:0]                   idx;
  logic [1:0]                    region;
  logic [1:0]                    word;
  logic                          dec_err;
  logic                          setup;
  logic [CH_T_DATA_WIDTH-1:0]    commit_word;
  logic [31:0]                   rdata;
  logic                          unused_paddr;

  assign paddr        = bus.paddr_i;
  assign region       = paddr[15:14];
  assign idx          = paddr[13:2];
  assign word         = idx[1:0];
  assign setup        = bus.psel_i && !bus.penable_i;
  // Byte-lane bits and anything above bit 15 carry no meaning here.
  assign unused_paddr = ^paddr;

  always_comb begin
    dec_err = 1'b1;
    unique case (region)
      2'b00, 2'b01: dec_err = (32'(idx) >= MAP_DEPTH);
      2'b10:        dec_err = (idx[11:9] != 3'b000) || (32'(word) >= NW);
      default:      dec_err = 1'b1;
    endcase
  end

  // Writing the top word commits the whole glyph: new word on top, lower words from the shadow.
  always_comb begin
    commit_word = shadow_q;
    commit_word[32*(NW-1) +: 32] = bus.pwdata_i;
  end

  always_comb begin
    state_d    = state_q;
    region_d   = region_q;
    word_d     = word_q;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    col_addr_d = col_addr_q;
    ch_addr_d  = ch_addr_q;
    cht_addr_d = cht_addr_q;
    col_data_d = '0;
    ch_data_d  = '0;
    cht_data_d = '0;
    col_wen_d  = 1'b0;
    ch_wen_d   = 1'b0;
    cht_wen_d  = 1'b0;
    shadow_d   = shadow_q;

    unique case (state_q)
      IDLE: begin
        if (setup) begin
          col_addr_d = idx[COL_MAP_ADDR_WIDTH-1:0];
          ch_addr_d  = idx[CH_MAP_ADDR_WIDTH-1:0];
          cht_addr_d = idx[2 +: CH_T_ADDR_WIDTH];
          region_d   = region;
          word_d     = word;
          if (dec_err) begin
            state_d   = ERR;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else if (bus.pwrite_i) begin
            // Outputs are registered, so the WR-cycle strobes are set up here.
            state_d  = WR;
            pready_d = 1'b1;
            unique case (region)
              2'b00: begin
                col_wen_d  = 1'b1;
                col_data_d = bus.pwdata_i[7:0];
              end
              2'b01: begin
                ch_wen_d  = 1'b1;
                ch_data_d = bus.pwdata_i[CH_MAP_DATA_WIDTH-1:0];
              end
              default: begin
                if (32'(word) == NW - 1) begin
                  cht_wen_d  = 1'b1;
                  cht_data_d = commit_word;
                end else begin
                  shadow_d[32*word +: 32] = bus.pwdata_i;
                end
              end
            endcase
          end else begin
            state_d = RD1;
          end
        end
      end
      RD1: begin
        // Master gave up during the wait state: drop it silently.
        if (!bus.psel_i) begin
          state_d = IDLE;
        end else begin
          state_d  = RD2;
          pready_d = 1'b1;
        end
      end
      WR, RD2, ERR: state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_arstn_i) begin
    if (!sys_arstn_i) begin
      state_q    <= IDLE;
      region_q   <= '0;
      word_q     <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      col_addr_q <= '0;
      col_data_q <= '0;
      col_wen_q  <= 1'b0;
      ch_addr_q  <= '0;
      ch_data_q  <= '0;
      ch_wen_q   <= 1'b0;
      cht_addr_q <= '0;
      cht_data_q <= '0;
      cht_wen_q  <= 1'b0;
      shadow_q   <= '0;
    end else begin
      state_q    <= state_d;
      region_q   <= region_d;
      word_q     <= word_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      col_addr_q <= col_addr_d;
      col_data_q <= col_data_d;
      col_wen_q  <= col_wen_d;
      ch_addr_q  <= ch_addr_d;
      ch_data_q  <= ch_data_d;
      ch_wen_q   <= ch_wen_d;
      cht_addr_q <= cht_addr_d;
      cht_data_q <= cht_data_d;
      cht_wen_q  <= cht_wen_d;
      shadow_q   <= shadow_d;
    end
  end

  // Read data is only available from the memories during RD2, so it is
  // muxed straight through rather than registered.
  always_comb begin
    rdata = '0;
    if (state_q == RD2) begin
      unique case (region_q)
        2'b00:   rdata = 32'(col_map_data_i);
        2'b01:   rdata = 32'(ch_map_data_i);
        2'b10:   rdata = ch_t_rw_data_i[32*word_q +: 32];
        default: rdata = '0;
      endcase
    end
  end

  assign bus.prdata_o  = rdata;
  assign bus.pready_o  = pready_q;
  assign bus.pslverr_o = pslverr_q;

  assign col_map_addr_o = col_addr_q;
  assign col_map_data_o = col_data_q;
  assign col_map_wen_o  = col_wen_q;
  assign ch_map_addr_o  = ch_addr_q;
  assign ch_map_data_o  = ch_data_q;
  assign ch_map_wen_o   = ch_wen_q;
  assign ch_t_rw_addr_o = cht_addr_q;
  assign ch_t_rw_data_o = cht_data_q;
  assign ch_t_rw_wen_o  = cht_wen_q;
endmodule

// File: tb/tb_apb_vgachargen_if.sv
// tb/tb_apb_vgachargen_if.sv - self-checking bench for apb_vgachargen_if
module tb_apb_vgachargen_if;
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [11:0]  col_addr, ch_addr;
  logic [7:0]   col_wdata, col_rdata, ch_wdata, ch_rdata;
  logic         col_wen, ch_wen, cht_wen;
  logic [6:0]   cht_addr;
  logic [127:0] cht_wdata, cht_rdata;

  apb_vgachargen_if_if #(.APB_ADDR_WIDTH(16)) bus ();

  apb_vgachargen_if dut (
    .sys_clk_i      (clk),
    .sys_arstn_i    (rstn),
    .bus            (bus.slave),
    .col_map_addr_o (col_addr),
    .col_map_data_o (col_wdata),
    .col_map_wen_o  (col_wen),
    .col_map_data_i (col_rdata),
    .ch_map_addr_o  (ch_addr),
    .ch_map_data_o  (ch_wdata),
    .ch_map_wen_o   (ch_wen),
    .ch_map_data_i  (ch_rdata),
    .ch_t_rw_addr_o (cht_addr),
    .ch_t_rw_data_o (cht_wdata),
    .ch_t_rw_wen_o  (cht_wen),
    .ch_t_rw_data_i (cht_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous memories with 1-cycle read latency, standing in for vgachargen.
  logic [7:0]   col_mem [4096];
  logic [7:0]   ch_mem  [4096];
  logic [127:0] cht_mem [128];

  always @(posedge clk) begin
    if (col_wen) col_mem[col_addr] <= col_wdata;
    if (ch_wen)  ch_mem[ch_addr]   <= ch_wdata;
    if (cht_wen) cht_mem[cht_addr] <= cht_wdata;
    col_rdata <= col_mem[col_addr];
    ch_rdata  <= ch_mem[ch_addr];
    cht_rdata <= cht_mem[cht_addr];
  end

  // Reference model: what the memories must hold and the glyph word shadow.
  logic [7:0]   m_col   [2400];
  logic [7:0]   m_ch    [2400];
  logic [127:0] m_glyph [128];
  logic [31:0]  m_sh    [4];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [31:0]  last_prdata;
  logic         last_slverr;
  logic [127:0] last_cht_data;
  logic [6:0]   last_cht_addr;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Every cycle: no response data outside a pready cycle, at most one strobe, strobes only alongside pready.
  always @(negedge clk) begin
    if (rstn && mon_en) begin
      chk("one_wen", ($countones({col_wen, ch_wen, cht_wen}) <= 1), 1'b1);
      if (!bus.pready_o) begin
        chk("prdata_idle", bus.prdata_o, 32'h0);
        chk("wen_no_pready", (col_wen | ch_wen | cht_wen), 1'b0);
      end
      if (bus.pslverr_o) chk("wen_on_err", (col_wen | ch_wen | cht_wen), 1'b0);
    end
  end

  task automatic idle_bus();
    @(negedge clk);
    bus.psel_i    = 1'b0;
    bus.penable_i = 1'b0;
  endtask

  task automatic xfer(input bit wr, input logic [15:0] addr, input logic [31:0] wdata);
    int           region, idx, word, cyc, exp_cyc;
    bit           err;
    logic [2:0]   exp_wen;
    logic [31:0]  exp_rd;
    logic [127:0] commit;
    region = int'(addr[15:14]);
    idx    = int'(addr[13:2]);
    word   = idx % 4;
    err    = (region == 3) || (region < 2 && idx >= 2400) ||
             (region == 2 && ((idx / 512) != 0 || word >= 4));
    exp_wen = 3'b000;
    exp_rd  = 32'h0;
    commit  = '0;
    if (!err && wr) begin
      if (region == 0) begin
        m_col[idx] = wdata[7:0];
        exp_wen = 3'b100;
      end else if (region == 1) begin
        m_ch[idx] = wdata[7:0];
        exp_wen = 3'b010;
      end else if (word == 3) begin
        commit = {wdata, m_sh[2], m_sh[1], m_sh[0]};
        m_glyph[idx / 4] = commit;
        exp_wen = 3'b001;
      end else begin
        m_sh[word] = wdata;
      end
    end
    if (!err && !wr) begin
      if (region == 0)      exp_rd = {24'h0, m_col[idx]};
      else if (region == 1) exp_rd = {24'h0, m_ch[idx]};
      else                  exp_rd = m_glyph[idx / 4][word*32 +: 32];
    end
    exp_cyc = (err || wr) ? 1 : 2;

    @(negedge clk);
    bus.psel_i    = 1'b1;
    bus.penable_i = 1'b0;
    bus.pwrite_i  = wr;
    bus.paddr_i   = addr;
    bus.pwdata_i  = wdata;
    @(negedge clk);
    bus.penable_i = 1'b1;
    // Address and data are only meaningful in the setup cycle.
    bus.paddr_i   = 16'($urandom);
    bus.pwdata_i  = $urandom;
    cyc = 1;
    while (!bus.pready_o && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    chk("access_cycles", cyc, exp_cyc);
    chk("pslverr", bus.pslverr_o, err);
    chk("prdata", bus.prdata_o, exp_rd);
    chk("wen_set", {col_wen, ch_wen, cht_wen}, exp_wen);
    if (exp_wen == 3'b100) begin
      chk("col_addr", col_addr, idx);
      chk("col_data", col_wdata, wdata[7:0]);
    end
    if (exp_wen == 3'b010) begin
      chk("ch_addr", ch_addr, idx);
      chk("ch_data", ch_wdata, wdata[7:0]);
    end
    if (exp_wen == 3'b001) begin
      chk("cht_addr", cht_addr, idx / 4);
      chk("cht_data", cht_wdata, commit);
    end
    last_prdata   = bus.prdata_o;
    last_slverr   = bus.pslverr_o;
    last_cht_data = cht_wdata;
    last_cht_addr = cht_addr;
  endtask

  initial begin
    logic [15:0] a;
    int          r, ix;
    bus.psel_i    = 1'b0;
    bus.penable_i = 1'b0;
    bus.pwrite_i  = 1'b0;
    bus.paddr_i   = '0;
    bus.pwdata_i  = '0;
    for (int i = 0; i < 4096; i++) begin
      col_mem[i] = 8'h0;
      ch_mem[i]  = 8'h0;
    end
    for (int i = 0; i < 128; i++) begin
      cht_mem[i] = '0;
      m_glyph[i] = '0;
    end
    for (int i = 0; i < 2400; i++) begin
      m_col[i] = 8'h0;
      m_ch[i]  = 8'h0;
    end
    for (int i = 0; i < 4; i++) m_sh[i] = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst_pready", bus.pready_o, 1'b0);
    chk("rst_pslverr", bus.pslverr_o, 1'b0);
    chk("rst_prdata", bus.prdata_o, 32'h0);
    chk("rst_wens", {col_wen, ch_wen, cht_wen}, 3'b000);
    chk("rst_addrs", {col_addr, ch_addr, cht_addr}, 31'h0);
    chk("rst_data", {col_wdata, ch_wdata, cht_wdata}, '0);
    rstn = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 2400; i++) xfer(1'b1, 16'(4 * i), 32'(i & 8'hFF));
    for (int i = 0; i < 2400; i++) xfer(1'b0, 16'(4 * i), 32'h0);
    xfer(1'b0, 16'h0048, 32'h0);
    chk("col_lit_0x12", last_prdata, 32'h12);

    for (int i = 0; i < 2400; i++) xfer(1'b1, 16'(16'h4000 + 4 * i), $urandom);
    for (int i = 0; i < 2400; i++) xfer(1'b0, 16'(16'h4000 + 4 * i), 32'h0);
    xfer(1'b1, 16'h6580, 32'h5A);
    chk("ch_oob_slverr", last_slverr, 1'b1);
    idle_bus();

    xfer(1'b1, 16'h8050, 32'h11111111);
    xfer(1'b1, 16'h8054, 32'h22222222);
    xfer(1'b1, 16'h8058, 32'h33333333);
    xfer(1'b1, 16'h805C, 32'h44444444);
    chk("glyph5_data_lit", last_cht_data, 128'h44444444_33333333_22222222_11111111);
    chk("glyph5_addr_lit", last_cht_addr, 7'd5);
    xfer(1'b0, 16'h8058, 32'h0);
    chk("glyph5_w2_lit", last_prdata, 32'h33333333);

    xfer(1'b0, 16'hC000, 32'h0);
    chk("c000_rd_slverr", last_slverr, 1'b1);
    xfer(1'b1, 16'hC000, 32'hFFFF_FFFF);
    chk("c000_wr_slverr", last_slverr, 1'b1);
    idle_bus();

    // Reset asserted during the read wait state.
    @(negedge clk);
    bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0; bus.paddr_i = 16'h0010;
    @(negedge clk);
    bus.penable_i = 1'b1;
    chk("rd1_pready", bus.pready_o, 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk("arst_pready", bus.pready_o, 1'b0);
    chk("arst_prdata", bus.prdata_o, 32'h0);
    chk("arst_wens", {col_wen, ch_wen, cht_wen}, 3'b000);
    for (int i = 0; i < 4; i++) m_sh[i] = 32'h0;
    idle_bus();
    @(negedge clk);
    rstn = 1'b1;
    xfer(1'b0, 16'h0010, 32'h0);
    chk("post_rst_lit", last_prdata, 32'h4);
    idle_bus();

    // psel dropped during the wait state: no response at all.
    @(negedge clk);
    bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0; bus.paddr_i = 16'h4004;
    @(negedge clk);
    bus.penable_i = 1'b1;
    chk("abort_rd1", bus.pready_o, 1'b0);
    bus.psel_i = 1'b0; bus.penable_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_resp", bus.pready_o, 1'b0);
    end

    // Back-to-back write then read with no idle cycle.
    xfer(1'b1, 16'h0040, 32'h000000A5);
    xfer(1'b0, 16'h0040, 32'h0);
    chk("b2b_lit", last_prdata, 32'hA5);

    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      a = 16'(4 * $urandom_range(0, 2405));
      else if (r < 6) a = 16'(16'h4000 + 4 * $urandom_range(0, 2405));
      else if (r < 9) begin
        ix = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 511);
        a = 16'(16'h8000 + 4 * ix);
      end else a = 16'(16'hC000 + 4 * $urandom_range(0, 4095));
      xfer($urandom_range(0, 1) == 1, a, $urandom);
      if ($urandom_range(0, 3) == 0) idle_bus();
    end
    idle_bus();
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
